// File: rtl/ethii_rx_parser.sv
// Ethernet II receive deframer: strips the 14-byte header, presents it on a
// per-protocol header channel, realigns the payload to 32-bit boundaries and
// steers it to the ARP or IPv4 consumer by EtherType. Everything else is
// dropped and counted.
module ethii_rx_parser #(
    parameter logic [47:0] LOCAL_MAC     = 48'h0,
    parameter bit          MAC_FILTER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] rx_tdata_i,
    input  logic        rx_tvld_i,
    input  logic        rx_tlast_i,
    input  logic [3:0]  rx_tkeep_i,
    output logic        rx_trdy_o,

    output logic [47:0] arp_mac_dest_o,
    output logic [47:0] arp_mac_src_o,
    output logic [15:0] arp_mac_type_o,
    output logic        arp_mac_vld_o,
    input  logic        arp_mac_rdy_i,
    output logic [31:0] arp_tdata_o,
    output logic        arp_tvld_o,
    output logic        arp_tlast_o,
    output logic [3:0]  arp_tkeep_o,
    input  logic        arp_trdy_i,

    output logic [47:0] ipv4_mac_dest_o,
    output logic [47:0] ipv4_mac_src_o,
    output logic [15:0] ipv4_mac_type_o,
    output logic        ipv4_mac_vld_o,
    input  logic        ipv4_mac_rdy_i,
    output logic [31:0] ipv4_tdata_o,
    output logic        ipv4_tvld_o,
    output logic        ipv4_tlast_o,
    output logic [3:0]  ipv4_tkeep_o,
    input  logic        ipv4_trdy_i,

    output logic [15:0] rx_drop_cnt_o
);

    typedef enum logic [2:0] {
        S_W0, S_W1, S_W2, S_W3, S_PAY, S_FLUSH, S_DROP
    } state_t;

    state_t      state, state_nx;

    // header fields gathered over W0..W2
    logic [47:0] dest_r;
    logic [47:0] src_r;

    // 16-bit holding register for realignment
    logic [15:0] held;
    logic [1:0]  held_keep;

    // shared payload output register; sel = 1 steers it to IPv4
    logic        sel;
    logic        out_vld;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    // W3 reached the FLUSH state with the flush word already loaded
    logic        flush_loaded;

    logic [15:0] drop_cnt;

    // decoded control from the next-state process
    logic        trdy;
    logic        hdr_load;
    logic        hold_load;
    logic        out_load;
    logic [31:0] out_nd;
    logic [3:0]  out_nk;
    logic        out_nl;
    logic        drop_inc;
    logic        flush_set;
    logic        flush_clr;

    logic        sel_trdy;
    logic        out_free;
    logic        is_arp;
    logic        is_ipv4;
    logic        mac_ok;
    logic        w3_runt;
    logic        w3_accept;
    logic        tgt_busy;

    assign sel_trdy  = sel ? ipv4_trdy_i : arp_trdy_i;
    assign out_free  = !out_vld || sel_trdy;
    assign is_arp    = (rx_tdata_i[31:16] == 16'h0806);
    assign is_ipv4   = (rx_tdata_i[31:16] == 16'h0800);
    assign mac_ok    = !MAC_FILTER_EN || (dest_r == LOCAL_MAC) || (dest_r == '1);
    assign w3_runt   = rx_tlast_i && !rx_tkeep_i[1];
    assign w3_accept = !w3_runt && mac_ok && (is_arp || is_ipv4);
    assign tgt_busy  = is_arp ? arp_mac_vld_o : ipv4_mac_vld_o;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_W0;
        else          state <= state_nx;
    end

    // Next-state, input ready and datapath strobes
    always_comb begin
        state_nx  = state;
        trdy      = 1'b1;
        hdr_load  = 1'b0;
        hold_load = 1'b0;
        out_load  = 1'b0;
        out_nd    = '0;
        out_nk    = '0;
        out_nl    = 1'b0;
        drop_inc  = 1'b0;
        flush_set = 1'b0;
        flush_clr = 1'b0;
        case (state)
            S_W0, S_W1, S_W2: begin
                if (rx_tvld_i) begin
                    if (rx_tlast_i) begin
                        drop_inc = 1'b1;
                        state_nx = S_W0;
                    end else begin
                        state_nx = (state == S_W0) ? S_W1 :
                                   (state == S_W1) ? S_W2 : S_W3;
                    end
                end
            end
            S_W3: begin
                // An accepted frame needs a free header slot and must not
                // retarget the payload register while a word is still pending.
                if (w3_accept && (tgt_busy || !out_free)) trdy = 1'b0;
                if (rx_tvld_i && trdy) begin
                    if (w3_accept) begin
                        hdr_load = 1'b1;
                        if (rx_tlast_i) begin
                            out_load  = 1'b1;
                            out_nd    = {rx_tdata_i[15:0], 16'h0};
                            out_nk    = {rx_tkeep_i[1:0], 2'b00};
                            out_nl    = 1'b1;
                            flush_set = 1'b1;
                            state_nx  = S_FLUSH;
                        end else begin
                            hold_load = 1'b1;
                            state_nx  = S_PAY;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        state_nx = rx_tlast_i ? S_W0 : S_DROP;
                    end
                end
            end
            S_PAY: begin
                trdy = out_free;
                if (rx_tvld_i && trdy) begin
                    out_load  = 1'b1;
                    out_nd    = {held, rx_tdata_i[31:16]};
                    out_nk    = {held_keep, rx_tkeep_i[3:2]};
                    out_nl    = rx_tlast_i && !rx_tkeep_i[1];
                    hold_load = 1'b1;
                    if (rx_tlast_i) state_nx = rx_tkeep_i[1] ? S_FLUSH : S_W0;
                end
            end
            S_FLUSH: begin
                trdy = 1'b0;
                if (flush_loaded) begin
                    flush_clr = 1'b1;
                    state_nx  = S_W0;
                end else if (out_free) begin
                    out_load = 1'b1;
                    out_nd   = {held, 16'h0};
                    out_nk   = {held_keep, 2'b00};
                    out_nl   = 1'b1;
                    state_nx = S_W0;
                end
            end
            S_DROP: begin
                if (rx_tvld_i && rx_tlast_i) state_nx = S_W0;
            end
            default: state_nx = S_W0;
        endcase
    end

    // Capture destination and source MAC from W0..W2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dest_r <= '0;
            src_r  <= '0;
        end else if (rx_tvld_i && trdy) begin
            case (state)
                S_W0: dest_r[47:16] <= rx_tdata_i;
                S_W1: begin
                    dest_r[15:0]  <= rx_tdata_i[31:16];
                    src_r[47:32]  <= rx_tdata_i[15:0];
                end
                S_W2: src_r[31:0] <= rx_tdata_i;
                default: ;
            endcase
        end
    end

    // Per-protocol header registers and payload steering select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arp_mac_dest_o  <= '0;
            arp_mac_src_o   <= '0;
            arp_mac_type_o  <= '0;
            arp_mac_vld_o   <= 1'b0;
            ipv4_mac_dest_o <= '0;
            ipv4_mac_src_o  <= '0;
            ipv4_mac_type_o <= '0;
            ipv4_mac_vld_o  <= 1'b0;
            sel             <= 1'b0;
        end else begin
            if (arp_mac_vld_o && arp_mac_rdy_i)   arp_mac_vld_o  <= 1'b0;
            if (ipv4_mac_vld_o && ipv4_mac_rdy_i) ipv4_mac_vld_o <= 1'b0;
            if (hdr_load) begin
                sel <= is_ipv4;
                if (is_arp) begin
                    arp_mac_dest_o <= dest_r;
                    arp_mac_src_o  <= src_r;
                    arp_mac_type_o <= rx_tdata_i[31:16];
                    arp_mac_vld_o  <= 1'b1;
                end else begin
                    ipv4_mac_dest_o <= dest_r;
                    ipv4_mac_src_o  <= src_r;
                    ipv4_mac_type_o <= rx_tdata_i[31:16];
                    ipv4_mac_vld_o  <= 1'b1;
                end
            end
        end
    end

    // Realignment holding register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held      <= '0;
            held_keep <= '0;
        end else if (hold_load) begin
            held      <= rx_tdata_i[15:0];
            held_keep <= rx_tkeep_i[1:0];
        end
    end

    // Shared payload output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else if (out_load) begin
            out_vld  <= 1'b1;
            out_data <= out_nd;
            out_keep <= out_nk;
            out_last <= out_nl;
        end else if (out_vld && sel_trdy) begin
            out_vld  <= 1'b0;
        end
    end

    // Flush-word-already-loaded flag for the W3 -> FLUSH path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       flush_loaded <= 1'b0;
        else if (flush_set) flush_loaded <= 1'b1;
        else if (flush_clr) flush_loaded <= 1'b0;
    end

    // Saturating dropped-frame counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         drop_cnt <= '0;
        else if (drop_inc && drop_cnt != '1)  drop_cnt <= drop_cnt + 16'd1;
    end

    assign rx_trdy_o     = trdy;
    assign rx_drop_cnt_o = drop_cnt;

    assign arp_tvld_o    = out_vld && !sel;
    assign arp_tdata_o   = sel ? '0 : out_data;
    assign arp_tkeep_o   = sel ? '0 : out_keep;
    assign arp_tlast_o   = !sel && out_last;

    assign ipv4_tvld_o   = out_vld && sel;
    assign ipv4_tdata_o  = sel ? out_data : '0;
    assign ipv4_tkeep_o  = sel ? out_keep : '0;
    assign ipv4_tlast_o  = sel && out_last;

endmodule
